// File: rtl/ssram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ssram_ctrl_pkg
// Brief   : State encoding and op codes shared by the SSRAM initiator.
// Config  : SSRAM_CTRL_TURN_EN adds the bus turnaround state.
// Revision: 1.0
// ============================================================================
package ssram_ctrl_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD_A = 3'd2,
    ST_RD_D = 3'd3
`ifdef SSRAM_CTRL_TURN_EN
    ,
    ST_TURN = 3'd4
`endif
  } ssram_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/ssram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ssram_ctrl
// Brief   : Single-beat valid/ready initiator for a synchronous SSRAM bus.
// Config  : define SSRAM_CTRL_TURN_EN to insert a dead cycle between a read
//           and a following write.
// Revision: 1.0
// ============================================================================
module ssram_ctrl
  import ssram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  ssram_ctrl_state_t       state_q, state_d;
  logic                    accept;
  logic                    mem_cs_q, mem_cs_d;
  logic                    mem_we_q, mem_we_d;
  logic                    mem_oe_q, mem_oe_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  // Held low through reset so a waiting requester is never accepted mid-reset.
  assign req_ready = rst_n && ((state_q == ST_IDLE) || (state_q == ST_WR) ||
                               (state_q == ST_RD_D));
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_WR: begin
        if (accept) state_d = (req_we == OP_WRITE) ? ST_WR : ST_RD_A;
        else        state_d = ST_IDLE;
      end
      ST_RD_A: state_d = ST_RD_D;
      ST_RD_D: begin
        if (accept && (req_we == OP_WRITE)) begin
`ifdef SSRAM_CTRL_TURN_EN
          state_d = ST_TURN;
`else
          state_d = ST_WR;
`endif
        end else if (accept) begin
          state_d = ST_RD_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef SSRAM_CTRL_TURN_EN
      ST_TURN: state_d = ST_WR;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values are decoded from the upcoming state so every mem_* pin is a flop.
  always_comb begin
    mem_cs_d    = (state_d == ST_WR) || (state_d == ST_RD_A) || (state_d == ST_RD_D);
    mem_we_d    = (state_d == ST_WR);
    mem_oe_d    = (state_d == ST_RD_A) || (state_d == ST_RD_D);
    mem_addr_d  = accept ? req_addr  : mem_addr_q;
    wdata_d     = accept ? req_wdata : wdata_q;
    rsp_valid_d = (state_q == ST_RD_D);
    rsp_rdata_d = (state_q == ST_RD_D) ? mem_data : rsp_rdata_q;
  end

  assign mem_data  = mem_we_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;
  assign mem_addr  = mem_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ssram_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ssram_ctrl
// Brief   : Directed bench for ssram_ctrl with an SSRAM model and a
//           transaction-level scoreboard. Honours SSRAM_CTRL_TURN_EN.
// Revision: 1.0
// ============================================================================
module tb_ssram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [9:0] mem_addr;
  wire  [7:0] mem_data;
  logic       mem_cs, mem_we, mem_oe;

  ssram_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  always #5 clk = ~clk;

  // SSRAM model: latches the addressed word on a read edge, drives it next cycle
  logic [7:0] sram [0:1023];
  logic [7:0] sr_rd_q;
  logic       sr_vld_q;
  logic       sr_drv;
  assign sr_drv   = mem_cs && mem_oe && !mem_we && sr_vld_q;
  assign mem_data = sr_drv ? sr_rd_q : 8'hzz;

  always @(posedge clk) begin
    if (mem_cs && mem_we) sram[mem_addr] <= mem_data;
    sr_vld_q <= mem_cs && mem_oe && !mem_we;
    if (mem_cs && mem_oe && !mem_we) sr_rd_q <= sram[mem_addr];
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int wr_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: in-order shadow memory; each accepted read is due 3 cycles later
  typedef struct { int due; logic [7:0] data; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] shadow [0:1023];
  logic [7:0] exp_rdata = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_rdata = 8'h00;
      chk("rst_cs_we_oe", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_bus_z", {31'd0, mem_data === 8'hzz}, 32'd1);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        exp_rdata = exp_q[0].data;
        void'(exp_q.pop_front());
      end else begin
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd0);
      end
      chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rdata});
      chk("bus_contention", {31'd0, mem_cs && mem_we && sr_drv}, 32'd0);
      if (!(mem_cs && mem_we) && !sr_drv)
        chk("bus_float", {31'd0, mem_data === 8'hzz}, 32'd1);
      if (mem_cs && mem_we) wr_cycles++;
      if (req_valid && req_ready) begin
        if (req_we) shadow[req_addr] = req_wdata;
        else        exp_q.push_back('{cyc + 3, shadow[req_addr]});
      end
    end
  end

  // Call at posedge+2; returns at posedge+2 just after the accepting edge.
  task automatic do_req(input logic we, input logic [9:0] a, input logic [7:0] d,
                        output int waits);
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1; waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) begin
      n_chk++;
      $display("FAIL req_timeout: got ready=0 required ready=1 within 20 cycles");
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [9:0] a, input logic [7:0] exp);
    int w;
    do_req(1'b0, a, 8'h00, w);
    @(negedge clk);
    chk({name, "_lat0"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({name, "_lat1"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({name, "_data"}, {24'd0, rsp_rdata}, {24'd0, exp});
    @(posedge clk); #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int wr_before;
    int bad;
    for (int i = 0; i < 1024; i++) begin
      sram[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    sr_vld_q = 1'b0;
    sr_rd_q = 8'h00;

    // 1: reset with a pending request
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h123; req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("t1_ready_low", {31'd0, req_ready}, 32'd0);
    chk("t1_pins_low", {29'd0, mem_cs, mem_we, mem_oe}, 32'd0);
    chk("t1_addr_zero", {22'd0, mem_addr}, 32'd0);
    chk("t1_rdata_zero", {24'd0, rsp_rdata}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // 2: write then read-back
    do_req(1'b1, 10'h005, 8'h3A, w);
    rd_check("t2_rd005", 10'h005, 8'h3A);

    // 3: four back-to-back writes
    wr_before = wr_cycles;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 10'(i), 8'(8'h10 + i), w);
      if (i > 0) chk("t3_no_stall", w, 0);
    end
    @(negedge clk);
    @(posedge clk); #2;
    chk("t3_wr_cycles", wr_cycles - wr_before, 4);

    // 4: read followed by write to the same address
    do_req(1'b0, 10'h001, 8'h00, w);
    do_req(1'b1, 10'h001, 8'h55, w);
    chk("t4_write_wait", w, 1);
    @(negedge clk);
`ifdef SSRAM_CTRL_TURN_EN
    chk("t4_turn_dead", {30'd0, mem_cs, mem_we}, 32'd0);
    @(negedge clk);
`endif
    chk("t4_wr_cycle", {30'd0, mem_cs, mem_we}, 32'd3);
    @(posedge clk); #2;
    rd_check("t4_reread", 10'h001, 8'h55);

    // 5: reads across the address wrap
    do_req(1'b1, 10'h3FF, 8'hA5, w);
    do_req(1'b0, 10'h3FF, 8'h00, w);
    do_req(1'b0, 10'h000, 8'h00, w);
    @(negedge clk);
    chk("t5_first_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t5_first_data", {24'd0, rsp_rdata}, 32'hA5);
    @(negedge clk);
    chk("t5_gap", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("t5_second_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t5_second_data", {24'd0, rsp_rdata}, 32'h10);
    @(posedge clk); #2;

    // 6: reset lands while in RD_D
    do_req(1'b0, 10'h002, 8'h00, w);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("t6_no_rsp_late", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    rd_check("t6_after_rst", 10'h001, 8'h55);
    repeat (3) @(posedge clk);
    #2;

    bad = 0;
    for (int i = 0; i < 1024; i++) if (sram[i] !== shadow[i]) bad++;
    chk("mem_image", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
